memory_bus_arbiter: RTL
=======================

Name: memory_bus_arbiter

Overview:
- Two-master arbiter sharing the single core memory bus (REQ/LOCK/ORDER/RW/ADDR/DATA, VALID/BUSY, 64-bit read data) between master 0 (instruction fetch) and master 1 (load/store).
- Round-robin grant per request cycle; in-order tag FIFO routes each read response back to its issuer.
- Sits between the core's two bus masters and the external memory port / memory model.

Parameters:
- P_TAG_DEPTH, 4, max outstanding reads (power of two, 2..16)
- P_TAG_DEPTH_N, 2, log2(P_TAG_DEPTH)

Ports:
- iCLOCK  in  1  core clock
- inRESET  in  1  async active-low reset
- iM0_REQ  in  1  master 0 request
- oM0_LOCK  out  1  master 0 stall: request not accepted this cycle
- iM0_ORDER  in  2  00 byte, 01 2-byte, 10 word, 11 none
- iM0_RW  in  1  1 write, 0 read
- iM0_ADDR  in  32  address
- iM0_DATA  in  32  write data
- oM0_VALID  out  1  read data valid to master 0
- iM0_BUSY  in  1  master 0 cannot take response
- oM0_DATA  out  64  read data
- iM1_* / oM1_*  same set as master 0, for master 1
- oMEMORY_REQ, oMEMORY_ORDER[2], oMEMORY_RW, oMEMORY_ADDR[32], oMEMORY_DATA[32]  out  downstream request
- iMEMORY_LOCK  in  1  downstream cannot accept
- iMEMORY_VALID  in  1  read response valid
- oMEMORY_BUSY  out  1  backpressure to memory response
- iMEMORY_DATA  in  64  read response data
- oERROR  out  1  sticky: response with empty tag FIFO

Behaviour:
- Clock and reset: one clock, iCLOCK; reset inRESET is asynchronous, active-low.
- Reset values:
  - Priority pointer = 0 (master 0 preferred).
  - Tag FIFO empty, count 0, oERROR 0.
  - oM0_LOCK and oM1_LOCK are combinational; with no requests they are 0.
- Grant (combinational):
  - Candidate = requesting master.
  - If both request, the candidate is the master indicated by the priority pointer.
  - A read candidate is blocked when the FIFO is full and no pop occurs this cycle.
  - Write candidates are never blocked by the FIFO.
- Downstream drive:
  - oMEMORY_REQ = candidate exists and is not blocked.
  - ORDER/RW/ADDR/DATA are muxed from the candidate; when idle they are 0.
- Acceptance:
  - A request is accepted in a cycle where oMEMORY_REQ=1 and iMEMORY_LOCK=0.
  - The accepted master sees LOCK=0.
  - Every other requesting master sees LOCK=1 and must hold its request stable.
- Priority update, on the clock edge after an acceptance:
  - Pointer becomes the opposite of the accepted master.
  - No acceptance leaves the pointer unchanged.
- Tag FIFO:
  - An accepted read pushes the master ID (1 bit).
  - Writes push nothing and get no response.
- Response routing:
  - Head tag selects the destination.
  - oMEMORY_BUSY = iMx_BUSY of the head master; 0 when the FIFO is empty.
  - oMx_VALID = iMEMORY_VALID and FIFO non-empty and head==x.
  - oMx_DATA = iMEMORY_DATA when valid, else 0.
  - Pop when iMEMORY_VALID and !oMEMORY_BUSY and FIFO non-empty.
  - Response latency through the arbiter: 0 cycles (combinational).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full FIFO with a same-cycle pop: a read may be accepted.
  - Pointers wrap modulo P_TAG_DEPTH.
- Errors:
  - iMEMORY_VALID with an empty FIFO: response dropped, no VALID to any master.
  - oERROR is set next edge and stays set until reset.
- Ordering: responses are assumed in request order; the arbiter never reorders.
- Reset mid-operation: outstanding tags are discarded; later stray responses set oERROR.

Test Plan:
- Single master: M0 reads 0x0000_1000, ORDER=10, memory returns 0x1122_3344_5566_7788 -> oM0_VALID one cycle with that data, oM1_VALID=0, FIFO count back to 0.
- Contention: M0 and M1 both read every cycle, pointer=0 -> accepted sequence M0,M1,M0,M1; the losing master's LOCK=1 each cycle; responses routed in the same order.
- Backpressure:
  - Hold iMEMORY_LOCK=1 for 3 cycles with both requesting -> no acceptance, pointer unchanged, both LOCK=1.
  - Then release -> the pointer-selected master is granted first.
- FIFO full:
  - Issue 4 M1 reads with no responses -> 5th read gets LOCK=1.
  - An M0 write to 0x0002_0000 in the same cycle is accepted.
  - Respond once -> the 5th read is accepted in that cycle.
- Response stall: head tag M0, iM0_BUSY=1 for 2 cycles -> oMEMORY_BUSY=1, no pop; iM0_BUSY=0 -> delivered, popped.
- Error and reset:
  - iMEMORY_VALID with empty FIFO -> no VALID, oERROR=1 next cycle, sticky.
  - Assert inRESET with 2 reads outstanding -> FIFO empty, oERROR=0, pointer=0 immediately.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin sharing of one memory bus between two masters,
// with an in-order tag FIFO that steers each read response back to its issuer.
module memory_bus_arbiter #(
    parameter int P_TAG_DEPTH   = 4,
    parameter int P_TAG_DEPTH_N = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iM0_REQ,
    output logic        oM0_LOCK,
    input  logic [1:0]  iM0_ORDER,
    input  logic        iM0_RW,
    input  logic [31:0] iM0_ADDR,
    input  logic [31:0] iM0_DATA,
    output logic        oM0_VALID,
    input  logic        iM0_BUSY,
    output logic [63:0] oM0_DATA,
    input  logic        iM1_REQ,
    output logic        oM1_LOCK,
    input  logic [1:0]  iM1_ORDER,
    input  logic        iM1_RW,
    input  logic [31:0] iM1_ADDR,
    input  logic [31:0] iM1_DATA,
    output logic        oM1_VALID,
    input  logic        iM1_BUSY,
    output logic [63:0] oM1_DATA,
    output logic        oMEMORY_REQ,
    output logic [1:0]  oMEMORY_ORDER,
    output logic        oMEMORY_RW,
    output logic [31:0] oMEMORY_ADDR,
    output logic [31:0] oMEMORY_DATA,
    input  logic        iMEMORY_LOCK,
    input  logic        iMEMORY_VALID,
    output logic        oMEMORY_BUSY,
    input  logic [63:0] iMEMORY_DATA,
    output logic        oERROR
);
    logic                     ptr;
    logic [P_TAG_DEPTH-1:0]   tags;
    logic [P_TAG_DEPTH_N-1:0] wr_ptr, rd_ptr;
    logic [P_TAG_DEPTH_N:0]   count;
    logic empty, full, head, pop, push, accept, cand, cand_rw, blocked;

    always_comb begin
        empty        = count == '0;
        full         = count == (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);
        head         = tags[rd_ptr];
        oMEMORY_BUSY = !empty && (head ? iM1_BUSY : iM0_BUSY);
        pop          = iMEMORY_VALID && !oMEMORY_BUSY && !empty;
        cand         = (iM0_REQ && iM1_REQ) ? ptr : iM1_REQ;
        cand_rw      = cand ? iM1_RW : iM0_RW;
        // a pop in the same cycle frees the slot a blocked read needs
        blocked      = !cand_rw && full && !pop;
        oMEMORY_REQ  = (iM0_REQ || iM1_REQ) && !blocked;
        accept       = oMEMORY_REQ && !iMEMORY_LOCK;
        push         = accept && !cand_rw;
        oM0_LOCK     = iM0_REQ && !(accept && !cand);
        oM1_LOCK     = iM1_REQ && !(accept && cand);
        oMEMORY_ORDER = !oMEMORY_REQ ? 2'b00 : cand ? iM1_ORDER : iM0_ORDER;
        oMEMORY_RW    = oMEMORY_REQ && cand_rw;
        oMEMORY_ADDR  = !oMEMORY_REQ ? 32'h0 : cand ? iM1_ADDR : iM0_ADDR;
        oMEMORY_DATA  = !oMEMORY_REQ ? 32'h0 : cand ? iM1_DATA : iM0_DATA;
        oM0_VALID     = iMEMORY_VALID && !empty && !head;
        oM1_VALID     = iMEMORY_VALID && !empty && head;
        oM0_DATA      = oM0_VALID ? iMEMORY_DATA : 64'h0;
        oM1_DATA      = oM1_VALID ? iMEMORY_DATA : 64'h0;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            ptr    <= 1'b0;
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            oERROR <= 1'b0;
        end else begin
            if (accept) ptr <= !cand;
            if (push) begin
                tags[wr_ptr] <= cand;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count  <= count + (P_TAG_DEPTH_N+1)'(push) - (P_TAG_DEPTH_N+1)'(pop);
            oERROR <= oERROR || (iMEMORY_VALID && empty);
        end
    end
endmodule
